// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: shared types and constants for the load/store unit.
package rv_lsu_pkg;
  typedef struct packed {
    logic memory;
    logic pc_next;
  } res_src_t;
  typedef enum logic {IDLE, WAIT} lsu_state_t;
  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;
endpackage

// File: rtl/rv_lsu_ldext.sv
// rv_lsu_ldext: picks the addressed byte/half/word out of a read word and sign- or zero-extends it.
module rv_lsu_ldext
  import rv_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sx;
  always_comb begin
    w_b    = i_rdata[{i_off, 3'b000} +: 8];
    w_h    = i_rdata[{i_off[1], 4'b0000} +: 16];
    w_sx   = !i_funct3[2];
    o_data = i_funct3[1:0] == LSU_SZ_W ? i_rdata :
             i_funct3[1:0] == LSU_SZ_H ? {{16{w_sx & w_h[15]}}, w_h} :
                                         {{24{w_sx & w_b[7]}}, w_b};
  end
endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: memory stage with a single-outstanding req/ack bus access and registered writeback.
// Optional bus-ack timeout enabled by defining RV_LSU_TIMEOUT_EN.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic [31:0] i_add,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  input  logic [2:0]  i_funct3,
  input  logic        i_store,
  input  res_src_t    i_res_src,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_pc_next,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wsel,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_write,
  output logic        o_bus_err
);
  lsu_state_t  r_state;
  logic [31:0] r_addr, r_wdata, r_wb_data;
  logic [3:0]  r_wsel;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd, r_wb_rd;
  logic        r_reg_write, r_bus_req, r_bus_we, r_wb_write, r_cancel;
  logic        w_mem_op;
  logic [31:0] w_ld_data;

  rv_lsu_ldext u_ldext (
    .i_rdata  (i_bus_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ld_data)
  );

  always_comb begin
    w_mem_op    = i_res_src.memory | i_store;
    o_stall     = r_state == IDLE ? w_mem_op & !i_flush : !i_bus_ack;
    o_bus_req   = r_bus_req;
    o_bus_we    = r_bus_we;
    o_bus_addr  = {r_addr[31:2], 2'b00};
    o_bus_wdata = r_wdata;
    o_bus_wsel  = r_wsel;
    o_wb_data   = r_wb_data;
    o_wb_rd     = r_wb_rd;
    o_wb_write  = r_wb_write;
  end

`ifdef RV_LSU_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_bus_err;
  assign o_bus_err = r_bus_err;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign o_bus_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wsel      <= '0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_wb_data   <= '0;
      r_wb_rd     <= '0;
      r_wb_write  <= 1'b0;
      r_cancel    <= 1'b0;
`ifdef RV_LSU_TIMEOUT_EN
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
`ifdef RV_LSU_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      if (r_state == IDLE) begin
        r_cancel <= 1'b0;
        if (w_mem_op && !i_flush) begin
          r_state     <= WAIT;
          r_addr      <= i_add;
          r_wdata     <= i_wdata;
          r_wsel      <= i_store ? i_wsel : 4'b1111;
          r_funct3    <= i_funct3;
          r_rd        <= i_rd;
          r_reg_write <= i_reg_write;
          r_bus_req   <= 1'b1;
          r_bus_we    <= i_store;
          r_wb_write  <= 1'b0;
`ifdef RV_LSU_TIMEOUT_EN
          r_cnt       <= '0;
`endif
        end else begin
          r_wb_data  <= i_res_src.pc_next ? i_pc_next : i_alu_result;
          r_wb_rd    <= i_rd;
          r_wb_write <= i_reg_write & !i_flush;
        end
      end else if (i_bus_ack) begin
        r_state    <= IDLE;
        r_bus_req  <= 1'b0;
        r_bus_we   <= 1'b0;
        r_cancel   <= 1'b0;
        r_wb_rd    <= r_rd;
        r_wb_write <= !r_bus_we & r_reg_write & !r_cancel & !i_flush;
        if (!r_bus_we) r_wb_data <= w_ld_data;
      end else begin
        if (i_flush) r_cancel <= 1'b1;
`ifdef RV_LSU_TIMEOUT_EN
        if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          r_state    <= IDLE;
          r_bus_req  <= 1'b0;
          r_bus_we   <= 1'b0;
          r_cancel   <= 1'b0;
          r_wb_write <= 1'b0;
          r_bus_err  <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: scoreboard bench for rv_lsu; expected writebacks and bus requests are queued at issue.
module tb_rv_lsu;
  import rv_lsu_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, flush, store, reg_write, bus_ack, stall, bus_req, bus_we, wb_write, bus_err;
  logic [31:0] add, alu_result, wdata, pc_next, bus_addr, bus_wdata, bus_rdata, wb_data;
  logic [3:0]  wsel, bus_wsel;
  logic [2:0]  funct3;
  logic [4:0]  rd, wb_rd;
  res_src_t    res_src;

  rv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush), .i_add(add), .i_alu_result(alu_result),
    .i_wdata(wdata), .i_wsel(wsel), .i_funct3(funct3), .i_store(store), .i_res_src(res_src),
    .i_reg_write(reg_write), .i_rd(rd), .i_pc_next(pc_next), .o_stall(stall), .o_bus_req(bus_req),
    .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_wsel(bus_wsel),
    .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata), .o_wb_data(wb_data), .o_wb_rd(wb_rd),
    .o_wb_write(wb_write), .o_bus_err(bus_err)
  );

  typedef struct {logic [31:0] d; logic [4:0] rd;} wb_t;
  typedef struct {logic [31:0] a; logic we; logic [3:0] sel; logic [31:0] wd;} bus_t;
  wb_t  wb_q[$];
  bus_t bus_q[$];
  wb_t  we_e;
  bus_t be_e;
  int   checks = 0, errors = 0, stall_cnt = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (wb_write) begin
      if (wb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got data %h rd %0d want none", wb_data, wb_rd);
      end else begin
        we_e = wb_q.pop_front();
        chk("wb_data", wb_data, we_e.d);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, we_e.rd});
      end
    end
    if (bus_req && !prev_req) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got addr %h want none", bus_addr);
      end else begin
        be_e = bus_q.pop_front();
        chk("bus_addr", bus_addr, be_e.a);
        chk("bus_we", {31'd0, bus_we}, {31'd0, be_e.we});
        chk("bus_wsel", {28'd0, bus_wsel}, {28'd0, be_e.sel});
        if (be_e.we) chk("bus_wdata", bus_wdata, be_e.wd);
      end
    end
    prev_req = bus_req;
  end

  task automatic nop();
    flush = 0; add = '0; alu_result = '0; wdata = '0; wsel = '0; funct3 = '0; store = 0;
    res_src = '0; reg_write = 0; rd = '0; pc_next = '0; bus_ack = 0; bus_rdata = '0;
  endtask

  task automatic alu_op(input logic [31:0] alu, input logic [31:0] pcn, input logic link,
                        input logic [4:0] r, input logic rw, input logic fl);
    @(posedge clk); #1;
    if (rw && !fl) wb_q.push_back('{link ? pcn : alu, r});
    stall_cnt = 0;
    alu_result = alu; pc_next = pcn; res_src.pc_next = link; rd = r; reg_write = rw; flush = fl;
    @(posedge clk); #1; nop();
    @(negedge clk);
    chk("alu_stall", stall_cnt, 0);
  endtask

  task automatic mem_op(input logic [31:0] a, input logic [2:0] f3, input logic st,
                        input logic [3:0] sel, input logic [31:0] wd, input logic [4:0] r,
                        input logic rw, input int waits, input logic [31:0] rdat,
                        input logic fl_wait, input logic [31:0] exp);
    @(posedge clk); #1;
    bus_q.push_back('{{a[31:2], 2'b00}, st, st ? sel : 4'b1111, wd});
    if (!st && rw && !fl_wait) wb_q.push_back('{exp, r});
    stall_cnt = 0;
    add = a; funct3 = f3; store = st; res_src.memory = !st; wsel = sel; wdata = wd; rd = r; reg_write = rw;
    @(posedge clk); #1; nop();
    for (int k = 0; k < waits; k++) begin
      flush = fl_wait && k == 0;
      @(negedge clk);
      chk("req_held", {31'd0, bus_req}, 1);
      @(posedge clk); #1; flush = 0;
    end
    bus_ack = 1; bus_rdata = rdat;
    @(posedge clk); #1; bus_ack = 0; bus_rdata = '0;
    @(negedge clk);
    chk("req_dropped", {31'd0, bus_req}, 0);
    chk("mem_stall", stall_cnt, 1 + waits);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'd0, bus_req}, 0);
    chk({tag, "_we"}, {31'd0, bus_we}, 0);
    chk({tag, "_stall"}, {31'd0, stall}, 0);
    chk({tag, "_wbw"}, {31'd0, wb_write}, 0);
    chk({tag, "_wbrd"}, {27'd0, wb_rd}, 0);
    chk({tag, "_wsel"}, {28'd0, bus_wsel}, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_err"}, {31'd0, bus_err}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    nop(); rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk_reset_vals("rst");
    @(posedge clk); #1; rst_n = 1;

    alu_op(32'h1234, 32'h0, 0, 5'd5, 1, 0);
    alu_op(32'hDEAD, 32'h400, 1, 5'd1, 1, 0);
    alu_op(32'h55, 32'h0, 0, 5'd0, 1, 0);
    alu_op(32'h77, 32'h0, 0, 5'd3, 1, 1);

    mem_op(32'h103, 3'b000, 0, 4'h0, 0, 5'd10, 1, 3, 32'h80FF_0000, 0, 32'hFFFF_FF80);
    mem_op(32'h103, 3'b100, 0, 4'h0, 0, 5'd11, 1, 3, 32'h80FF_0000, 0, 32'h0000_0080);
    mem_op(32'h102, 3'b001, 0, 4'h0, 0, 5'd12, 1, 1, 32'h80FF_0000, 0, 32'hFFFF_80FF);
    mem_op(32'h100, 3'b101, 0, 4'h0, 0, 5'd13, 1, 0, 32'h1234_8001, 0, 32'h0000_8001);
    mem_op(32'h100, 3'b001, 0, 4'h0, 0, 5'd14, 1, 2, 32'h1234_8001, 0, 32'hFFFF_8001);
    mem_op(32'h101, 3'b000, 0, 4'h0, 0, 5'd15, 1, 0, 32'h0000_7F00, 0, 32'h0000_007F);
    mem_op(32'h104, 3'b010, 0, 4'h0, 0, 5'd16, 1, 1, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
    mem_op(32'h202, 3'b001, 1, 4'b1100, 32'hBEEF_BEEF, 5'd0, 0, 0, 0, 0, 0);
    mem_op(32'h108, 3'b010, 0, 4'h0, 0, 5'd7, 1, 2, 32'h1111_2222, 1, 0);

    @(posedge clk); #1;
    add = 32'h300; funct3 = 3'b010; res_src.memory = 1; reg_write = 1; rd = 5'd9; flush = 1;
    @(negedge clk); chk("flush_idle_stall", {31'd0, stall}, 0);
    @(posedge clk); #1; nop();
    @(negedge clk);
    chk("flush_idle_req", {31'd0, bus_req}, 0);
    chk("flush_idle_wbw", {31'd0, wb_write}, 0);

    @(posedge clk); #1;
    bus_q.push_back('{32'h400, 1'b0, 4'hF, 32'h0});
    add = 32'h400; funct3 = 3'b010; res_src.memory = 1; reg_write = 1; rd = 5'd4;
    @(posedge clk); #1; nop();
    @(negedge clk); chk("pre_rst_req", {31'd0, bus_req}, 1);
    @(posedge clk); #1; rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk); chk_reset_vals("midrst");
    @(posedge clk); #1; rst_n = 1;

    @(posedge clk); #1; bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); chk("idle_ack_stall", {31'd0, stall}, 0);
    @(posedge clk); #1; nop();
    @(negedge clk);
    chk("idle_ack_req", {31'd0, bus_req}, 0);
    chk("idle_ack_wbw", {31'd0, wb_write}, 0);

`ifdef RV_LSU_TIMEOUT_EN
    @(posedge clk); #1;
    bus_q.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
    add = 32'h500; funct3 = 3'b010; res_src.memory = 1; reg_write = 1; rd = 5'd6;
    @(posedge clk); #1; nop();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_wait_err", {31'd0, bus_err}, 0);
      chk("to_wait_stall", {31'd0, stall}, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_err", {31'd0, bus_err}, 1);
    chk("to_stall", {31'd0, stall}, 0);
    chk("to_req", {31'd0, bus_req}, 0);
    chk("to_wbw", {31'd0, wb_write}, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("to_err_pulse", {31'd0, bus_err}, 0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wb_q_drained", wb_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_lsu.md
Name: rv_lsu

Overview:
- Memory-access stage directly downstream of the ALU output stage.
- Consumes store data and byte enables, the effective address, `funct3`, `res_src`, `rd` and `reg_write`.
- Runs a single-outstanding request/ack transaction on the data bus, with load alignment and sign/zero extension.
- Registers the final writeback value and destination; stalls the upstream pipeline while a bus access is pending.

Parameters:
- `TIMEOUT_CYCLES`, 255, bus-ack cycles waited before a timeout error. Used only with `RV_LSU_TIMEOUT_EN`; 8-bit counter.

Ports:
- `i_clk` in 1: clock.
- `i_reset_n` in 1: synchronous active-low reset.
- `i_flush` in 1: kill the instruction in this stage.
- `i_add` in 32: effective address from the ALU.
- `i_alu_result` in 32: ALU result.
- `i_wdata` in 32: replicated store data.
- `i_wsel` in 4: store byte enables.
- `i_funct3` in 3: access size/sign (`[1:0]` size, `[2]` unsigned).
- `i_store` in 1: store instruction.
- `i_res_src` in `res_src_t`: writeback source (`.memory` = load, `.pc_next` = link).
- `i_reg_write` in 1: register write enable.
- `i_rd` in 5: destination register.
- `i_pc_next` in 32: PC+4 for link writeback.
- `o_stall` out 1: hold the upstream stages.
- `o_bus_req` out 1: bus request.
- `o_bus_we` out 1: bus write.
- `o_bus_addr` out 32: word address, bits `[1:0]` forced to 0.
- `o_bus_wdata` out 32: store data.
- `o_bus_wsel` out 4: byte enables.
- `i_bus_ack` in 1: transaction complete.
- `i_bus_rdata` in 32: read data, valid with ack.
- `o_wb_data` out 32: writeback value.
- `o_wb_rd` out 5: writeback register.
- `o_wb_write` out 1: writeback enable.
- `o_bus_err` out 1: timeout pulse. Present only with `RV_LSU_TIMEOUT_EN`; tied to 0 otherwise.

Behaviour:
- Clock and reset:
  - Single clock `i_clk`.
  - `i_reset_n` is synchronous active-low; all state is cleared on the `i_clk` edge where it is sampled low.
- Reset values: state IDLE; `o_bus_req`, `o_bus_we`, `o_stall`, `o_wb_write` = 0; `o_wb_rd` = 0; `o_bus_wsel` = 0; `o_wb_data` = 0.
- `mem_op` = `i_res_src.memory | i_store`.
- State IDLE:
  - Non-memory op: next edge registers `o_wb_data` (`i_pc_next` if `i_res_src.pc_next`, else `i_alu_result`), `o_wb_rd` = `i_rd`, `o_wb_write` = `i_reg_write`. Latency 1; no stall.
  - `mem_op` and no `i_flush`: `o_stall` = 1 combinationally. Next edge latches address, data, wsel, funct3, rd and reg_write; sets `o_bus_req` = 1 and `o_bus_we` = `i_store`; goes to WAIT; `o_wb_write` = 0.
  - For loads, `o_bus_wsel` = 4'b1111.
- State WAIT:
  - `o_stall` = `!i_bus_ack`.
  - On `i_bus_ack`: drop `o_bus_req` at the next edge and return to IDLE.
  - Load on ack: register extracted data to `o_wb_data`, with `o_wb_write` = latched reg_write.
  - Store on ack: `o_wb_write` = 0.
  - Minimum memory-op latency: accept cycle + ack cycle + 1, with writeback valid the cycle after ack.
- Load extraction:
  - Byte = `rdata[8*addr[1:0] +: 8]`; half = `rdata[16*addr[1] +: 16]`; word = `rdata`.
  - Sign-extend when `funct3[2]` = 0, zero-extend when 1.
- `i_flush` in IDLE: the incoming op is discarded; `o_wb_write` = 0 next cycle.
- `i_flush` in WAIT:
  - The transaction is not aborted; `o_bus_req` holds until ack.
  - A cancel flag is set, suppressing `o_wb_write` for that op.
  - The flag clears on return to IDLE.
- `i_bus_ack` in IDLE is ignored.
- `rdata` is sampled only in the ack cycle.
- Reset mid-WAIT: the request is dropped immediately and the result is lost; the bus must tolerate this.
- `rd` = 0 with `reg_write` = 1 is passed through as-is; the register file ignores x0.

Optional Feature:
- Macro `RV_LSU_TIMEOUT_EN`.
- When defined:
  - An 8-bit counter runs in WAIT and is cleared on entry.
  - If it reaches `TIMEOUT_CYCLES` without ack: `o_bus_err` pulses 1 cycle, `o_bus_req` drops, state returns to IDLE and `o_wb_write` = 0.
  - Ack arriving in the same cycle as the limit takes priority, so no error is raised.
- When undefined: no counter; WAIT is unbounded; `o_bus_err` = 0.

Decomposition:
- `res_src_t` comes from the shared structs package.
- Add to that package:
  - `lsu_state_t` enum (IDLE, WAIT).
  - Size constants `LSU_SZ_B` = 2'b00, `LSU_SZ_H` = 2'b01, `LSU_SZ_W` = 2'b10.
- Sub-module `rv_lsu_ldext`: combinational extraction/extension of `rdata` + `addr[1:0]` + `funct3`.

Test Plan:
- Non-memory op: `alu_result` 0x1234, `rd` 5, `reg_write` 1 -> next cycle `o_wb_data` 0x1234, `o_wb_rd` 5, `o_wb_write` 1, `o_stall` never 1.
- Load `LB` (`funct3` 000) at addr 0x103, ack after 3 wait cycles, `rdata` 0x80FF_0000:
  - `o_bus_addr` 0x100; `o_stall` high 4 cycles.
  - `o_wb_data` 0xFFFF_FF80.
  - Same with `LBU` (`funct3` 100) -> 0x0000_0080.
- Store `SH` at addr 0x202, `wsel` 4'b1100, `wdata` 0xBEEF_BEEF, immediate ack:
  - `o_bus_we` 1, `o_bus_wsel` 1100.
  - `o_wb_write` stays 0; 1 stall cycle.
- `i_flush` during WAIT of load `LW` to `rd` 7 -> `o_bus_req` held until ack, then `o_wb_write` remains 0.
- Reset asserted in WAIT -> next edge `o_bus_req` 0, state IDLE, all outputs at reset values.
- With `RV_LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES` 4, ack never arrives -> `o_bus_err` 1 for exactly one cycle after 4 WAIT cycles, `o_stall` drops, `o_wb_write` 0.
